// File: rtl/pc_sequencer.sv
// Program counter and hardware return stack for the 5401 core.
// Commands are captured on PH1 and executed on the next PH2; both phases are enables on CLK.
module pc_sequencer #(
  parameter int PC_WIDTH    = 11,
  parameter int STACK_DEPTH = 4
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   PH1,
  input  logic                                   PH2,
  input  logic [1:0]                             OP,
  input  logic                                   HOLD,
  input  logic [PC_WIDTH-1:0]                    TARGET,
  output logic [PC_WIDTH-1:0]                    PC,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       SP,
  output logic                                   OVF,
  output logic                                   UNF
);

  localparam int SP_WIDTH = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_WIDTH-1:0] SP_FULL = SP_WIDTH'(STACK_DEPTH);

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_JMP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  // Captured command (PH1)
  op_e                 op_q;
  logic                hold_q;
  logic [PC_WIDTH-1:0] target_q;

  // Architectural state
  logic [PC_WIDTH-1:0] pc_q, pc_next;
  logic [SP_WIDTH-1:0] sp_q, sp_next;
  logic [PC_WIDTH-1:0] stack_q    [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_next [STACK_DEPTH];
  logic                ovf_q, ovf_next;
  logic                unf_q, unf_next;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] top_entry;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  // Slot selection by comparison keeps every array index a loop constant.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_WIDTH'(i + 1)) top_entry = stack_q[i];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_next    = pc_q;
    sp_next    = sp_q;
    stack_next = stack_q;
    ovf_next   = ovf_q;
    unf_next   = unf_q;

    if (PH2 && !hold_q) begin
      unique case (op_q)
        OP_INC: pc_next = pc_inc;
        OP_JMP: pc_next = target_q;
        OP_CALL: begin
          pc_next = target_q;
          if (sp_q == SP_FULL) begin
            // Full: the oldest return address falls off the bottom.
            for (int i = 0; i < STACK_DEPTH - 1; i++) stack_next[i] = stack_q[i + 1];
            stack_next[STACK_DEPTH-1] = pc_inc;
            ovf_next = 1'b1;
          end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (sp_q == SP_WIDTH'(i)) stack_next[i] = pc_inc;
            end
            sp_next = sp_q + SP_WIDTH'(1);
          end
        end
        OP_RET: begin
          if (sp_q == '0) begin
            pc_next  = '0;
            unf_next = 1'b1;
          end else begin
            pc_next = top_entry;
            sp_next = sp_q - SP_WIDTH'(1);
          end
        end
        default: pc_next = pc_q;
      endcase
    end
  end

  // NOTE: the stack is a handful of flops, so it is reset along with everything else.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q     <= OP_INC;
      hold_q   <= 1'b0;
      target_q <= '0;
      pc_q     <= '0;
      sp_q     <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      if (PH1) begin
        op_q     <= op_e'(OP);
        hold_q   <= HOLD;
        target_q <= TARGET;
      end
      pc_q    <= pc_next;
      sp_q    <= sp_next;
      stack_q <= stack_next;
      ovf_q   <= ovf_next;
      unf_q   <= unf_next;
    end
  end

  assign PC  = pc_q;
  assign SP  = sp_q;
  assign OVF = ovf_q;
  assign UNF = unf_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and return-stack unit for the 5401 core. It sits directly downstream of the two-phase clock generator and consumes its CLK1/CLK2 phase outputs as synchronous enables, all on the master clock. Each PH1 cycle captures the next-PC command from instruction decode. The following PH2 cycle applies it to the PC and a small hardware return stack. PC drives the program-memory address bus.

Parameters:
PC_WIDTH, 11, width of program counter and stack entries
STACK_DEPTH, 4, number of return-stack entries (≥1)

Ports:
CLK  input  1  master clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
PH1  input  1  phase-1 enable (clock_gen CLK1); command capture cycle
PH2  input  1  phase-2 enable (clock_gen CLK2); command execute cycle
OP  input  2  command: 00 INC, 01 JMP, 10 CALL, 11 RET
HOLD  input  1  stall: when captured high, the next PH2 leaves all state unchanged
TARGET  input  PC_WIDTH  jump/call destination
PC  output  PC_WIDTH  current program counter (registered)
SP  output  $clog2(STACK_DEPTH+1)  number of valid stack entries, 0..STACK_DEPTH
OVF  output  1  sticky: CALL executed with stack full
UNF  output  1  sticky: RET executed with stack empty

Behaviour:
- Reset (RST high at a CLK edge): PC=0, SP=0, all stack entries=0, OVF=0, UNF=0. Captured command is set to INC with HOLD=0. RST has priority over PH1/PH2. Reset asserted mid-operation discards any captured command.
- Capture: on an edge with PH1=1, register OP, HOLD, TARGET. With PH1=0 the captured values are held. There is no other path from OP/HOLD/TARGET into state.
- Execute: on an edge with PH2=1 and captured HOLD=0, act on the captured command, one update per PH2 pulse:
  - INC: PC ← PC+1 modulo 2^PC_WIDTH; max value wraps to 0.
  - JMP: PC ← TARGET.
  - CALL with SP<STACK_DEPTH: push PC+1 (mod 2^PC_WIDTH) at position SP; SP ← SP+1; PC ← TARGET.
  - CALL with SP==STACK_DEPTH: shift the stack down, losing the oldest entry. The newest slot gets PC+1. SP stays at STACK_DEPTH, PC ← TARGET, OVF ← 1.
  - RET with SP>0: PC ← top entry; SP ← SP−1. The popped slot's contents are don't-care.
  - RET with SP==0: PC ← 0, SP stays 0, UNF ← 1.
- Captured HOLD=1 at PH2: PC, SP, stack and flags unchanged. The command is not retried; the next PH1 recaptures.
- PH1 and PH2 both high in one edge (not produced by clock_gen, but defined): execute the previously captured command and capture the new inputs in the same edge.
- PH2 without an intervening PH1: re-execute the same captured command (e.g. INC again).
- Latency: inputs valid at PH1 edge n are reflected on PC/SP/flags after the next PH2 edge. No combinational input→output paths.
- OVF/UNF clear only on reset.

Test Plan:
- Reset and INC: hold RST 2 cycles, then 3 PH1/PH2 pairs with OP=00 → PC 0→1→2→3, SP=0, OVF=UNF=0. PC changes only on PH2 edges.
- JMP and wrap: PC_WIDTH=11, JMP TARGET=0x7FF, then INC → PC=0x7FF, then 0x000.
- CALL/RET nesting: at PC=0x010, CALL 0x100, then CALL 0x200 → SP=2, PC=0x200. RET → PC=0x101, SP=1. RET → PC=0x011, SP=0.
- Overflow: 5 CALLs from PCs 0x000, 0x010, 0x020, 0x030, 0x040 → SP=4, OVF=1. Four RETs yield 0x041, 0x031, 0x021, 0x011 (0x001 lost). A 5th RET gives PC=0, UNF=1.
- HOLD and phase rules: HOLD=1 with OP=01, TARGET=0x055 → PC unchanged after PH2. Change OP/TARGET between PH1 and PH2 → the PH1-captured values are used. A PH2 with no PH1 repeats the captured command.
- Reset mid-stream: PH1 captures CALL 0x123, RST asserted before PH2 → PC=0, SP=0, and the next PH2 performs INC (PC=1).
